// File: rtl/store_data_pkg.sv
// Shared definitions for the two-bank parity memory write and read paths.
package store_data_pkg;
    localparam int BYTE_W     = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int ENTRIES    = 2 ** (DEF_ADDR_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/store_data_if.sv
// Byte stream handshake feeding the bank loader.
interface store_data_if;
    import store_data_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/store_data_parity_gen.sv
// Per-byte parity bit, shared with the read-path checker.
module parity_gen
    import store_data_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [BYTE_W-1:0] i_data,
    output logic              o_parity
);
    assign o_parity = (^i_data) ^ ODD_PARITY;
endmodule

// File: rtl/store_data.sv
// Loads a stream of bytes plus parity into two banks, steered by count MSB.
module store_data
    import store_data_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    store_data_if.slave       s,
    output logic              wr_en1,
    output logic              wr_en2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_num,
    output logic              wr_parity,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_count_nxt;
    logic                w_ready;
    logic                w_accept;
    logic                w_last;
    logic                w_parity;
    logic                r_wr_en1;
    logic                r_wr_en2;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [BYTE_W-1:0]   r_wr_num;
    logic                r_wr_parity;

    parity_gen #(
        .ODD_PARITY (ODD_PARITY)
    ) u_parity (
        .i_data   (s.in_data),
        .o_parity (w_parity)
    );

    assign w_ready    = (r_state == ST_LOAD) && !abort;
    assign w_accept   = w_ready && s.in_valid;
    assign w_last     = &r_count;
    assign s.in_ready = w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ST_LOAD;
                    w_count_nxt = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_accept) begin
                    // Final accept wraps count back to 0.
                    w_count_nxt = r_count + 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en1    <= 1'b0;
            r_wr_en2    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_num    <= '0;
            r_wr_parity <= 1'b0;
        end else begin
            r_wr_en1 <= w_accept && !r_count[ADDR_W];
            r_wr_en2 <= w_accept && r_count[ADDR_W];
            if (w_accept) begin
                r_wr_addr   <= r_count[ADDR_W-1:0];
                r_wr_num    <= s.in_data;
                r_wr_parity <= w_parity;
            end
        end
    end

    assign wr_en1    = r_wr_en1;
    assign wr_en2    = r_wr_en2;
    assign wr_addr   = r_wr_addr;
    assign wr_num    = r_wr_num;
    assign wr_parity = r_wr_parity;
    assign count     = r_count;
    assign busy      = (r_state == ST_LOAD);
    assign done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_store_data.sv
// Bench for store_data: even and odd parity instances driven in lockstep.
module tb_store_data;
    import store_data_pkg::*;

    localparam int AW = DEF_ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [7:0]    in_data;

    logic          e1   [2];
    logic          e2   [2];
    logic [AW-1:0] addr [2];
    logic [7:0]    num  [2];
    logic          par  [2];
    logic [AW:0]   cnt  [2];
    logic          bsy  [2];
    logic          dn   [2];
    logic          rdy  [2];
    logic [AW+17:0] outv [2];

    int vecs = 0;
    int errs = 0;

    store_data_if if0 ();
    store_data_if if1 ();

    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign rdy[0] = if0.in_ready;
    assign rdy[1] = if1.in_ready;

    store_data #(.ODD_PARITY(1'b0), .ADDR_W(AW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s(if0),
        .wr_en1(e1[0]), .wr_en2(e2[0]), .wr_addr(addr[0]), .wr_num(num[0]),
        .wr_parity(par[0]), .count(cnt[0]), .busy(bsy[0]), .done(dn[0])
    );

    store_data #(.ODD_PARITY(1'b1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s(if1),
        .wr_en1(e1[1]), .wr_en2(e2[1]), .wr_addr(addr[1]), .wr_num(num[1]),
        .wr_parity(par[1]), .count(cnt[1]), .busy(bsy[1]), .done(dn[1])
    );

    for (genvar d = 0; d < 2; d++) begin : g_outv
        assign outv[d] = {e1[d], e2[d], addr[d], num[d], par[d],
                          cnt[d], bsy[d], dn[d], rdy[d]};
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Parity from a population count, independent of any XOR reduction.
    function automatic logic ref_par(input logic [7:0] b, input bit odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return logic'((ones % 2) == 1) ^ logic'(odd);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
        #3;
        for (int d = 0; d < 2; d++) begin
            vecs++;
            if (outv[d] !== '0) begin
                errs++;
                $display("FAIL reset_outputs dut%0d: got %h want 0", d, outv[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        do_start();
        vecs++;
        if (bsy[0] !== 1'b1 || cnt[0] !== '0 || dn[0] !== 1'b0) begin
            errs++;
            $display("FAIL load_entry: busy=%b count=%0d done=%b want 1 0 0",
                     bsy[0], cnt[0], dn[0]);
        end
        for (int k = 0; k < ENTRIES; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            #1;
            vecs++;
            if (rdy[0] !== 1'b1) begin
                errs++;
                $display("FAIL full_ready k=%0d: got %b want 1", k, rdy[0]);
            end
            tick();
            vecs++;
            if (e1[0] !== logic'(k < 8) || e2[0] !== logic'(k >= 8) ||
                addr[0] !== AW'(k % 8) || num[0] !== 8'(k)) begin
                errs++;
                $display("FAIL full_write k=%0d: en1=%b en2=%b addr=%0d num=%h want %b %b %0d %h",
                         k, e1[0], e2[0], addr[0], num[0],
                         k < 8, k >= 8, k % 8, k);
            end
            vecs++;
            if (par[0] !== ref_par(8'(k), 1'b0) || par[1] !== ref_par(8'(k), 1'b1)) begin
                errs++;
                $display("FAIL full_parity k=%0d: got %b/%b want %b/%b", k, par[0], par[1],
                         ref_par(8'(k), 1'b0), ref_par(8'(k), 1'b1));
            end
            vecs++;
            if (cnt[0] !== (AW+1)'((k + 1) % ENTRIES)) begin
                errs++;
                $display("FAIL full_count k=%0d: got %0d want %0d", k, cnt[0], (k + 1) % ENTRIES);
            end
        end
        in_valid = 1'b0;
        vecs++;
        if (dn[0] !== 1'b1 || bsy[0] !== 1'b0 || cnt[0] !== '0) begin
            errs++;
            $display("FAIL full_done: done=%b busy=%b count=%0d want 1 0 0",
                     dn[0], bsy[0], cnt[0]);
        end
        tick();
        vecs++;
        if (e1[0] !== 1'b0 || e2[0] !== 1'b0 || num[0] !== 8'h0F || addr[0] !== AW'(7)) begin
            errs++;
            $display("FAIL full_hold: en1=%b en2=%b num=%h addr=%0d want 0 0 0f 7",
                     e1[0], e2[0], num[0], addr[0]);
        end
    endtask

    task automatic test_parity();
        logic [7:0] pat [2];
        pat[0] = 8'hFF;
        pat[1] = 8'h80;
        do_start();
        vecs++;
        if (dn[0] !== 1'b0 || bsy[0] !== 1'b1 || cnt[0] !== '0) begin
            errs++;
            $display("FAIL restart_from_done: done=%b busy=%b count=%0d want 0 1 0",
                     dn[0], bsy[0], cnt[0]);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = pat[i];
            tick();
            vecs++;
            if (par[0] !== ref_par(pat[i], 1'b0) || par[1] !== ref_par(pat[i], 1'b1)) begin
                errs++;
                $display("FAIL parity_%h: got %b/%b want %b/%b", pat[i], par[0], par[1],
                         ref_par(pat[i], 1'b0), ref_par(pat[i], 1'b1));
            end
        end
        do_abort();
    endtask

    task automatic test_stall();
        logic [7:0] b;
        do_start();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vecs++;
            if (cnt[0] !== (AW+1)'(5) || e1[0] !== 1'b0 || e2[0] !== 1'b0) begin
                errs++;
                $display("FAIL stall c=%0d: count=%0d en1=%b en2=%b want 5 0 0",
                         c, cnt[0], e1[0], e2[0]);
            end
        end
        b = 8'($urandom);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        vecs++;
        if (e1[0] !== 1'b1 || e2[0] !== 1'b0 || addr[0] !== AW'(5) ||
            num[0] !== b || cnt[0] !== (AW+1)'(6)) begin
            errs++;
            $display("FAIL stall_resume: en1=%b en2=%b addr=%0d num=%h count=%0d want 1 0 5 %h 6",
                     e1[0], e2[0], addr[0], num[0], cnt[0], b);
        end
        do_abort();
    endtask

    task automatic test_abort();
        logic [7:0] b;
        do_start();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        abort = 1'b1;
        #1;
        vecs++;
        if (rdy[0] !== 1'b0) begin
            errs++;
            $display("FAIL abort_ready: got %b want 0", rdy[0]);
        end
        tick();
        abort = 1'b0;
        #1;
        vecs++;
        if (cnt[0] !== '0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0 ||
            e1[0] !== 1'b0 || e2[0] !== 1'b0) begin
            errs++;
            $display("FAIL abort_idle: count=%0d busy=%b ready=%b en1=%b en2=%b want 0 0 0 0 0",
                     cnt[0], bsy[0], rdy[0], e1[0], e2[0]);
        end
        in_valid = 1'b0;
        tick();
        do_start();
        b = 8'($urandom);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        vecs++;
        if (e1[0] !== 1'b1 || e2[0] !== 1'b0 || addr[0] !== '0 || num[0] !== b) begin
            errs++;
            $display("FAIL abort_reload: en1=%b en2=%b addr=%0d num=%h want 1 0 0 %h",
                     e1[0], e2[0], addr[0], num[0], b);
        end
        do_abort();
    endtask

    task automatic test_async_reset();
        do_start();
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_data = 8'($urandom);
        vecs++;
        if (cnt[0] !== (AW+1)'(12)) begin
            errs++;
            $display("FAIL arst_pre_count: got %0d want 12", cnt[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vecs++;
            if (outv[d] !== '0) begin
                errs++;
                $display("FAIL arst_immediate dut%0d: got %h want 0", d, outv[d]);
            end
        end
        tick();
        vecs++;
        if (outv[0] !== '0) begin
            errs++;
            $display("FAIL arst_no_strobe: got %h want 0", outv[0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_trip();
        logic [7:0] m1 [8];
        logic [7:0] m2 [8];
        logic       p1 [8];
        logic       p2 [8];
        logic [7:0] q [$];
        logic [3:0] rc;
        logic [7:0] got;
        logic       gotp;
        logic       v;
        int cyc = 0;
        do_start();
        while (q.size() < ENTRIES && cyc < 400) begin
            v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = 8'($urandom);
            if (v) q.push_back(in_data);
            tick();
            if (e1[0] === 1'b1 && e2[0] === 1'b1) begin
                errs++;
                $display("FAIL rt_both_strobes cyc=%0d: en1=%b en2=%b want not both", cyc, e1[0], e2[0]);
            end
            if (e1[0] === 1'b1) begin m1[addr[0]] = num[0]; p1[addr[0]] = par[0]; end
            if (e2[0] === 1'b1) begin m2[addr[0]] = num[0]; p2[addr[0]] = par[0]; end
            cyc++;
        end
        in_valid = 1'b0;
        vecs++;
        if (q.size() != ENTRIES || dn[0] !== 1'b1) begin
            errs++;
            $display("FAIL rt_complete: accepted=%0d done=%b want %0d 1", q.size(), dn[0], ENTRIES);
        end
        for (int r = 0; r < ENTRIES && r < q.size(); r++) begin
            rc   = 4'(r);
            got  = rc[3] ? m2[rc[2:0]] : m1[rc[2:0]];
            gotp = rc[3] ? p2[rc[2:0]] : p1[rc[2:0]];
            vecs++;
            if (got !== q[r] || gotp !== ref_par(q[r], 1'b0)) begin
                errs++;
                $display("FAIL rt_entry %0d: num=%h par=%b want %h %b", r, got, gotp,
                         q[r], ref_par(q[r], 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_parity();
        test_stall();
        test_abort();
        test_async_reset();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
